// File: rtl/waterfall_deadlock_pkg.sv
// Shared definitions for the waterfall_sender deadlock monitors.
package waterfall_deadlock_pkg;

    // Monitor progression: no stall seen, stall being timed, deadlock declared.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        BLOCKED = 2'd2
    } monitor_state_e;

    // Stall duration used when a region monitor does not override it.
    localparam int DEFAULT_STALL_CYCLES = 16;

    // True when a cnt_w-bit saturating counter can reach stall_cycles.
    function automatic bit stall_fits(input int cnt_w, input int stall_cycles);
        longint max_val;
        if (cnt_w >= 62) begin
            return 1'b1;
        end
        max_val = (longint'(1) << cnt_w) - 1;
        return (max_val >= longint'(stall_cycles));
    endfunction

endpackage

// File: rtl/waterfall_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
module waterfall_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over increment; increment stops at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register, asynchronously zeroed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/waterfall_sender_axis_stall_monitor.sv
// Deadlock monitor for the waterfall_sender dataflow region: declares a
// deadlock once a stall persists STALL_CYCLES consecutive cycles and
// snapshots which AXIS channels were blocked at that moment.
module waterfall_sender_axis_stall_monitor
    import waterfall_deadlock_pkg::*;
#(
    parameter int NUM_AXIS     = 4,
    parameter int NUM_INST     = 2,
    parameter int STALL_CYCLES = DEFAULT_STALL_CYCLES,
    parameter int CNT_W        = 8,
    parameter int STICKY       = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic                block_pulse,
    output logic [NUM_AXIS-1:0] blocked_chan,
    output logic [CNT_W-1:0]    stall_count
);

    // Counter value seen on the edge that completes the STALL_CYCLES run.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(STALL_CYCLES - 1);

    // Reject configurations that could never detect a deadlock.
    generate
        if (!stall_fits(CNT_W, STALL_CYCLES)) begin : g_bad_cnt_w
            $error("CNT_W too narrow to reach STALL_CYCLES");
        end
        if ((NUM_AXIS < 1) || (NUM_INST < 1) || (STALL_CYCLES < 1)) begin : g_bad_size
            $error("NUM_AXIS, NUM_INST and STALL_CYCLES must all be at least 1");
        end
    endgenerate

    monitor_state_e      state_q;
    monitor_state_e      state_d;
    logic                block_pulse_q;
    logic                block_pulse_d;
    logic [NUM_AXIS-1:0] blocked_chan_q;
    logic [NUM_AXIS-1:0] blocked_chan_d;
    logic                stall_cond;

    // A region where every instance is idle is quiescent, not stalled.
    assign stall_cond = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);

    // Consecutive-stall counter; any non-stalled cycle or clear restarts it.
    waterfall_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (clear | ~stall_cond),
        .inc   (stall_cond),
        .count (stall_count)
    );

    // Next-state, detection pulse and channel snapshot; clear overrides everything.
    always_comb begin
        state_d        = state_q;
        block_pulse_d  = 1'b0;
        blocked_chan_d = '0;

        case (state_q)
            IDLE: begin
                if (stall_cond) begin
                    state_d = (STALL_CYCLES == 1) ? BLOCKED : COUNT;
                end
            end
            COUNT: begin
                if (!stall_cond) begin
                    state_d = IDLE;
                end else if (stall_count == LAST_COUNT) begin
                    state_d = BLOCKED;
                end
            end
            BLOCKED: begin
                if ((STICKY == 0) && !stall_cond) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d = IDLE;
        end

        // Snapshot is taken only on entry and then frozen until leaving BLOCKED.
        if (state_d == BLOCKED) begin
            if (state_q == BLOCKED) begin
                blocked_chan_d = blocked_chan_q;
            end else begin
                blocked_chan_d = axis_block_sigs;
                block_pulse_d  = 1'b1;
            end
        end
    end

    // State and output registers, asynchronously returned to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            block_pulse_q  <= 1'b0;
            blocked_chan_q <= '0;
        end else begin
            state_q        <= state_d;
            block_pulse_q  <= block_pulse_d;
            blocked_chan_q <= blocked_chan_d;
        end
    end

    assign block        = (state_q == BLOCKED);
    assign block_pulse  = block_pulse_q;
    assign blocked_chan = blocked_chan_q;

endmodule

// File: tb/tb_waterfall_sender_axis_stall_monitor.sv
// Directed scoreboard bench for waterfall_sender_axis_stall_monitor.
// Instance A: defaults (STICKY=1, STALL_CYCLES=16, CNT_W=8).
// Instance B: STICKY=0, STALL_CYCLES=1, CNT_W=2.
module tb_waterfall_sender_axis_stall_monitor;

    typedef struct {
        string      tag;
        logic       blk;
        logic       pls;
        logic [3:0] chan;
        logic [7:0] cnt;
    } exp_t;

    logic       clock;
    logic       rst;

    logic [3:0] a_axis;
    logic [1:0] a_idle;
    logic [1:0] a_iblk;
    logic       a_clear;
    logic       a_block;
    logic       a_pulse;
    logic [3:0] a_chan;
    logic [7:0] a_cnt;

    logic [3:0] b_axis;
    logic [1:0] b_idle;
    logic [1:0] b_iblk;
    logic       b_clear;
    logic       b_block;
    logic       b_pulse;
    logic [3:0] b_chan;
    logic [1:0] b_cnt;

    exp_t sb_a[$];
    exp_t sb_b[$];

    int errors = 0;
    int checks = 0;

    waterfall_sender_axis_stall_monitor u_dut_a (
        .clock           (clock),
        .reset           (rst),
        .axis_block_sigs (a_axis),
        .inst_idle_sigs  (a_idle),
        .inst_block_sigs (a_iblk),
        .clear           (a_clear),
        .block           (a_block),
        .block_pulse     (a_pulse),
        .blocked_chan    (a_chan),
        .stall_count     (a_cnt)
    );

    waterfall_sender_axis_stall_monitor #(
        .NUM_AXIS     (4),
        .NUM_INST     (2),
        .STALL_CYCLES (1),
        .CNT_W        (2),
        .STICKY       (0)
    ) u_dut_b (
        .clock           (clock),
        .reset           (rst),
        .axis_block_sigs (b_axis),
        .inst_idle_sigs  (b_idle),
        .inst_block_sigs (b_iblk),
        .clear           (b_clear),
        .block           (b_block),
        .block_pulse     (b_pulse),
        .blocked_chan    (b_chan),
        .stall_count     (b_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic blk, input logic pls,
                            input logic [3:0] chan, input logic [7:0] cnt);
        exp_t e;
        e.tag = tag; e.blk = blk; e.pls = pls; e.chan = chan; e.cnt = cnt;
        sb_a.push_back(e);
    endtask

    task automatic expect_b(input string tag, input logic blk, input logic pls,
                            input logic [3:0] chan, input logic [7:0] cnt);
        exp_t e;
        e.tag = tag; e.blk = blk; e.pls = pls; e.chan = chan; e.cnt = cnt;
        sb_b.push_back(e);
    endtask

    task automatic check_a();
        exp_t e;
        if (sb_a.size() == 0) begin
            chk("a_scoreboard_empty", 8'd0, 8'd1);
        end else begin
            e = sb_a.pop_front();
            $display("[%0t] A %s: block=%0b pulse=%0b chan=%b count=%0d", $time, e.tag,
                     a_block, a_pulse, a_chan, a_cnt);
            chk({e.tag, ".block"}, {7'd0, a_block}, {7'd0, e.blk});
            chk({e.tag, ".pulse"}, {7'd0, a_pulse}, {7'd0, e.pls});
            chk({e.tag, ".chan"}, {4'd0, a_chan}, {4'd0, e.chan});
            chk({e.tag, ".count"}, a_cnt, e.cnt);
        end
    endtask

    task automatic check_b();
        exp_t e;
        if (sb_b.size() == 0) begin
            chk("b_scoreboard_empty", 8'd0, 8'd1);
        end else begin
            e = sb_b.pop_front();
            $display("[%0t] B %s: block=%0b pulse=%0b chan=%b count=%0d", $time, e.tag,
                     b_block, b_pulse, b_chan, b_cnt);
            chk({e.tag, ".block"}, {7'd0, b_block}, {7'd0, e.blk});
            chk({e.tag, ".pulse"}, {7'd0, b_pulse}, {7'd0, e.pls});
            chk({e.tag, ".chan"}, {4'd0, b_chan}, {4'd0, e.chan});
            chk({e.tag, ".count"}, {6'd0, b_cnt}, e.cnt);
        end
    endtask

    task automatic step_a(input string tag, input logic blk, input logic pls,
                          input logic [3:0] chan, input logic [7:0] cnt);
        expect_a(tag, blk, pls, chan, cnt);
        tick();
        check_a();
    endtask

    task automatic step_b(input string tag, input logic blk, input logic pls,
                          input logic [3:0] chan, input logic [7:0] cnt);
        expect_b(tag, blk, pls, chan, cnt);
        tick();
        check_b();
    endtask

    initial begin
        rst     = 1'b1;
        a_axis  = 4'd0; a_idle = 2'd0; a_iblk = 2'd0; a_clear = 1'b0;
        b_axis  = 4'd0; b_idle = 2'd0; b_iblk = 2'd0; b_clear = 1'b0;

        // Reset state
        tick();
        tick();
        expect_a("reset", 1'b0, 1'b0, 4'd0, 8'd0);
        check_a();
        expect_b("reset", 1'b0, 1'b0, 4'd0, 8'd0);
        check_b();
        #1 rst = 1'b0;

        // Basic detection after 16 stalled edges, sticky hold, clear
        a_axis = 4'b0010;
        for (int i = 1; i <= 16; i++) begin
            step_a("t1_run", (i == 16), (i == 16), (i == 16) ? 4'b0010 : 4'b0000, 8'(i));
        end
        step_a("t1_hold", 1'b1, 1'b0, 4'b0010, 8'd17);
        a_axis = 4'b0110;
        step_a("t1_chan_stable", 1'b1, 1'b0, 4'b0010, 8'd18);
        a_axis = 4'b0000;
        step_a("t1_sticky", 1'b1, 1'b0, 4'b0010, 8'd0);
        step_a("t1_sticky2", 1'b1, 1'b0, 4'b0010, 8'd0);
        a_clear = 1'b1;
        step_a("t1_clear", 1'b0, 1'b0, 4'd0, 8'd0);
        a_clear = 1'b0;
        step_a("t1_idle", 1'b0, 1'b0, 4'd0, 8'd0);

        // 15-cycle run, one gap, then a full 16-cycle run
        a_axis = 4'b0010;
        for (int i = 1; i <= 15; i++) begin
            step_a("t2_short", 1'b0, 1'b0, 4'd0, 8'(i));
        end
        a_axis = 4'b0000;
        step_a("t2_gap", 1'b0, 1'b0, 4'd0, 8'd0);
        a_axis = 4'b0010;
        for (int i = 1; i <= 16; i++) begin
            step_a("t2_run", (i == 16), (i == 16), (i == 16) ? 4'b0010 : 4'b0000, 8'(i));
        end
        a_axis  = 4'b0000;
        a_clear = 1'b1;
        step_a("t2_clear", 1'b0, 1'b0, 4'd0, 8'd0);
        a_clear = 1'b0;

        // All instances idle masks every block flag
        a_idle = 2'b11; a_axis = 4'b1111; a_iblk = 2'b11;
        for (int i = 1; i <= 100; i++) begin
            step_a("t3_masked", 1'b0, 1'b0, 4'd0, 8'd0);
        end
        a_idle = 2'b01;
        step_a("t3_partial_idle", 1'b0, 1'b0, 4'd0, 8'd1);
        a_idle = 2'b00; a_axis = 4'b0000; a_iblk = 2'b00;
        step_a("t3_release", 1'b0, 1'b0, 4'd0, 8'd0);

        // Instance block flag alone detects; snapshot holds the (empty) AXIS flags
        a_iblk = 2'b10; a_idle = 2'b01;
        for (int i = 1; i <= 16; i++) begin
            step_a("t4_inst", (i == 16), (i == 16), 4'b0000, 8'(i));
        end
        a_iblk = 2'b00; a_idle = 2'b00; a_clear = 1'b1;
        step_a("t4_clear", 1'b0, 1'b0, 4'd0, 8'd0);
        a_clear = 1'b0;

        // Clear on the would-be detection edge wins
        a_axis = 4'b1000;
        for (int i = 1; i <= 15; i++) begin
            step_a("t5_run", 1'b0, 1'b0, 4'd0, 8'(i));
        end
        a_clear = 1'b1;
        step_a("t5_clear_on_detect", 1'b0, 1'b0, 4'd0, 8'd0);
        a_clear = 1'b0;
        step_a("t5_restart", 1'b0, 1'b0, 4'd0, 8'd1);
        a_axis = 4'b0000;
        step_a("t5_drop", 1'b0, 1'b0, 4'd0, 8'd0);

        // Asynchronous reset mid-count, then in BLOCKED
        a_axis = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            step_a("t6_count", 1'b0, 1'b0, 4'd0, 8'(i));
        end
        rst = 1'b1;
        #1;
        expect_a("t6_rst_mid_count", 1'b0, 1'b0, 4'd0, 8'd0);
        check_a();
        #1 rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step_a("t6_after_rst", (i == 16), (i == 16), (i == 16) ? 4'b0001 : 4'b0000, 8'(i));
        end
        rst = 1'b1;
        #1;
        expect_a("t6_rst_blocked", 1'b0, 1'b0, 4'd0, 8'd0);
        check_a();
        #1 rst = 1'b0;
        a_axis = 4'b0000;
        step_a("t6_idle", 1'b0, 1'b0, 4'd0, 8'd0);

        // Instance B: non-sticky, single-cycle detection, 2-bit saturation
        b_axis = 4'b0100;
        step_b("b_single", 1'b1, 1'b1, 4'b0100, 8'd1);
        b_axis = 4'b0000;
        step_b("b_drop", 1'b0, 1'b0, 4'd0, 8'd0);
        b_axis = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            step_b("b_sat", 1'b1, (i == 1), 4'b0100, (i < 3) ? 8'(i) : 8'd3);
        end
        b_axis = 4'b0000;
        step_b("b_end", 1'b0, 1'b0, 4'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
